// File: rtl/pu_conn_context_rd_pkg.sv
// Shared types and address-map constants for the PU connection-context read path.
package pu_conn_context_rd_pkg;

    localparam int PU_WIDTH_NBITS                 = 32;
    localparam int RCI_NBITS                      = 8;
    localparam int CONNECTION_CONTEXT_DEPTH_NBITS = 4;
    localparam int PU_MEM_ADDR_NBITS              = 16;
    localparam int PU_MEM_MULTI_DEPTH_MSB         = 15;
    localparam int PU_MEM_MULTI_DEPTH_LSB         = 12;
    localparam logic [3:0] PU_CONNECTION_CONTEXT_MEM = 4'h3;

    typedef struct packed {
        logic [1:0]                   op;
        logic [PU_MEM_ADDR_NBITS-1:0] addr;
        logic [PU_WIDTH_NBITS-1:0]    wdata;
    } io_type;

    typedef struct packed {
        logic [PU_WIDTH_NBITS-1:0] data;
        logic                      last;
        logic                      err;
    } rsp_entry_t;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} rd_state_t;

    // Read command toward the connection-context memory; all non-address fields stay zero.
    function automatic io_type cc_read_cmd(input logic [RCI_NBITS-1:0] rci,
                                           input logic [CONNECTION_CONTEXT_DEPTH_NBITS-1:0] offset);
        io_type cmd;
        cmd = '0;
        cmd.addr[PU_MEM_MULTI_DEPTH_MSB:PU_MEM_MULTI_DEPTH_LSB] = PU_CONNECTION_CONTEXT_MEM;
        cmd.addr[RCI_NBITS-1+CONNECTION_CONTEXT_DEPTH_NBITS:CONNECTION_CONTEXT_DEPTH_NBITS] = rci;
        cmd.addr[CONNECTION_CONTEXT_DEPTH_NBITS-1:0] = offset;
        return cmd;
    endfunction

endpackage

// File: rtl/sfifo2f_fo.sv
// Two-entry synchronous FIFO with fall-through head; occupancy exported for credit checks.
module sfifo2f_fo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr,
    input  logic [WIDTH-1:0] din,
    input  logic             rd,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count == 2'd0);
    assign rd_en = rd & ~empty;
    // A write into a full buffer is accepted only when the head leaves in the same cycle.
    assign wr_en = wr & ((count != 2'd2) | rd_en);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_en) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, wr_en} - {1'b0, rd_en};
        end
    end

endmodule

// File: rtl/pu_conn_context_rd.sv
// Per-PU burst read initiator: one outstanding io_req at a time, in-order responses
// through a 2-entry buffer, with ack timeout and stray-ack accounting.
module pu_conn_context_rd
    import pu_conn_context_rd_pkg::*;
#(
    parameter int WIDTH_NBITS   = PU_WIDTH_NBITS,
    parameter int LEN_NBITS     = 3,
    parameter int TIMEOUT_NBITS = 10
) (
    input  logic                                      clk,
    input  logic                                      rstn,
    input  logic                                      req_valid,
    output logic                                      req_ready,
    input  logic [RCI_NBITS-1:0]                      req_rci,
    input  logic [CONNECTION_CONTEXT_DEPTH_NBITS-1:0] req_offset,
    input  logic [LEN_NBITS-1:0]                      req_len,
    output logic                                      io_req,
    output io_type                                    io_cmd,
    input  logic                                      io_ack,
    input  logic [WIDTH_NBITS-1:0]                    io_ack_data,
    output logic                                      rsp_valid,
    input  logic                                      rsp_ready,
    output logic [WIDTH_NBITS-1:0]                    rsp_data,
    output logic                                      rsp_last,
    output logic                                      rsp_err,
    output logic [7:0]                                stray_ack_cnt
);

    localparam int CCD = CONNECTION_CONTEXT_DEPTH_NBITS;
    localparam logic [CCD-1:0]           OFF_ONE     = 1;
    localparam logic [LEN_NBITS-1:0]     LEN_ONE     = 1;
    localparam logic [TIMEOUT_NBITS-1:0] TCNT_ONE    = 1;
    localparam logic [TIMEOUT_NBITS-1:0] TIMEOUT_PRE = {{(TIMEOUT_NBITS-1){1'b1}}, 1'b0};

    rd_state_t                state;
    logic [RCI_NBITS-1:0]     rci_q;
    logic [CCD-1:0]           offset_q;
    logic [CCD-1:0]           offset_next;
    logic [LEN_NBITS-1:0]     len_q;
    logic [LEN_NBITS-1:0]     word_cnt;
    logic [TIMEOUT_NBITS-1:0] tcnt;

    rsp_entry_t push_entry;
    rsp_entry_t head;
    logic       push;
    logic       pop;
    logic       buf_empty;
    logic [1:0] buf_count;
    logic [1:0] next_count;
    logic       credit_ok;
    logic       is_last;
    logic       expire;

    assign is_last     = (word_cnt == len_q);
    assign offset_next = offset_q + OFF_ONE;
    assign expire      = (state == ST_WAIT) & ~io_ack & (tcnt == TIMEOUT_PRE);
    assign push        = ((state == ST_WAIT) & io_ack) | expire;
    assign pop         = rsp_valid & rsp_ready;
    // Credit looks at the occupancy after this edge so a read can follow its ack immediately.
    assign next_count  = buf_count + {1'b0, push} - {1'b0, pop};
    assign credit_ok   = (next_count < 2'd2);

    always_comb begin
        push_entry = '0;
        if (io_ack) begin
            push_entry.data = io_ack_data;
            push_entry.last = is_last;
        end else begin
            push_entry.last = 1'b1;
            push_entry.err  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            io_req    <= 1'b0;
            io_cmd    <= '0;
            rci_q     <= '0;
            offset_q  <= '0;
            len_q     <= '0;
            word_cnt  <= '0;
            tcnt      <= '0;
        end else begin
            io_req <= 1'b0;
            io_cmd <= '0;
            case (state)
                ST_IDLE: begin
                    if (req_valid & req_ready) begin
                        rci_q     <= req_rci;
                        offset_q  <= req_offset;
                        len_q     <= req_len;
                        word_cnt  <= '0;
                        req_ready <= 1'b0;
                        if (credit_ok) begin
                            io_req <= 1'b1;
                            io_cmd <= cc_read_cmd(req_rci, req_offset);
                            tcnt   <= '0;
                            state  <= ST_WAIT;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (credit_ok) begin
                        io_req <= 1'b1;
                        io_cmd <= cc_read_cmd(rci_q, offset_q);
                        tcnt   <= '0;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // An ack in the expiry cycle wins over the timeout.
                    if (io_ack) begin
                        if (is_last) begin
                            state     <= ST_IDLE;
                            req_ready <= 1'b1;
                        end else begin
                            word_cnt <= word_cnt + LEN_ONE;
                            offset_q <= offset_next;
                            if (credit_ok) begin
                                io_req <= 1'b1;
                                io_cmd <= cc_read_cmd(rci_q, offset_next);
                                tcnt   <= '0;
                            end else begin
                                state <= ST_ISSUE;
                            end
                        end
                    end else if (expire) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TCNT_ONE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stray_ack_cnt <= 8'd0;
        end else if (io_ack && (state != ST_WAIT) && (stray_ack_cnt != 8'hFF)) begin
            stray_ack_cnt <= stray_ack_cnt + 8'd1;
        end
    end

    sfifo2f_fo #(
        .WIDTH ($bits(rsp_entry_t))
    ) u_rsp_buf (
        .clk   (clk),
        .rstn  (rstn),
        .wr    (push),
        .din   (push_entry),
        .rd    (pop),
        .dout  (head),
        .empty (buf_empty),
        .count (buf_count)
    );

    assign rsp_valid = ~buf_empty;
    assign rsp_data  = buf_empty ? '0 : head.data;
    assign rsp_last  = ~buf_empty & head.last;
    assign rsp_err   = ~buf_empty & head.err;

endmodule

// File: tb/tb_pu_conn_context_rd.sv
// Self-checking bench: a scripted responder and consumer surround the DUT, and each
// test compares io_req addresses and delivered words against a burst-level model.
`timescale 1ns/1ps
module tb_pu_conn_context_rd;
    import pu_conn_context_rd_pkg::*;

    localparam int W   = PU_WIDTH_NBITS;
    localparam int CCD = CONNECTION_CONTEXT_DEPTH_NBITS;

    logic                 clk;
    logic                 rstn;
    logic                 req_valid;
    logic                 req_ready;
    logic [RCI_NBITS-1:0] req_rci;
    logic [CCD-1:0]       req_offset;
    logic [2:0]           req_len;
    logic                 io_req;
    io_type               io_cmd;
    logic                 io_ack;
    logic [W-1:0]         io_ack_data;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [W-1:0]         rsp_data;
    logic                 rsp_last;
    logic                 rsp_err;
    logic [7:0]           stray_ack_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int           ack_delay     = 1;
    int           mute_idx      = -1;
    bit           fixed_data_en = 0;
    logic [W-1:0] fixed_data    = '0;
    int           countdown     = 0;
    logic [W-1:0] pending       = '0;
    bit           late_ack_req  = 0;
    int           ready_mode    = 0;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        logic         err;
        int           c;
    } rsp_rec_t;

    logic [PU_MEM_ADDR_NBITS-1:0] req_addr_q[$];
    int                           req_cyc_q[$];
    logic [W-1:0]                 ack_data_q[$];
    int                           ack_cyc_q[$];
    rsp_rec_t                     rsp_q[$];

    pu_conn_context_rd dut (
        .clk           (clk),
        .rstn          (rstn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_rci       (req_rci),
        .req_offset    (req_offset),
        .req_len       (req_len),
        .io_req        (io_req),
        .io_cmd        (io_cmd),
        .io_ack        (io_ack),
        .io_ack_data   (io_ack_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_last      (rsp_last),
        .rsp_err       (rsp_err),
        .stray_ack_cnt (stray_ack_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder: acks each read ack_delay cycles after its io_req, except the muted one.
    initial begin
        io_ack      = 1'b0;
        io_ack_data = '0;
        forever begin
            @(posedge clk);
            #1;
            io_ack      = 1'b0;
            io_ack_data = '0;
            if (late_ack_req) begin
                io_ack       = 1'b1;
                io_ack_data  = 32'hDEAD_BEEF;
                late_ack_req = 0;
            end
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    io_ack      = 1'b1;
                    io_ack_data = pending;
                    ack_cyc_q.push_back(cyc);
                end
            end
            if (io_req === 1'b1) begin
                n_checks++;
                if (countdown != 0) begin
                    n_fail++;
                    $display("[TB] FAIL io_req_while_outstanding: ack countdown=%0d required 0", countdown);
                end
                n_checks++;
                if (io_cmd.op !== 2'b00 || io_cmd.wdata !== '0) begin
                    n_fail++;
                    $display("[TB] FAIL io_cmd_fields: op=%0h wdata=%0h required 0", io_cmd.op, io_cmd.wdata);
                end
                pending = fixed_data_en ? fixed_data : $urandom;
                if (req_addr_q.size() != mute_idx) countdown = ack_delay;
                req_addr_q.push_back(io_cmd.addr);
                req_cyc_q.push_back(cyc);
                ack_data_q.push_back(pending);
            end else if (rstn) begin
                n_checks++;
                if (io_cmd !== '0) begin
                    n_fail++;
                    $display("[TB] FAIL io_cmd_idle: io_cmd=%0h required 0", io_cmd);
                end
            end
        end
    end

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       rsp_ready = 1'b0;
                1:       rsp_ready = 1'b1;
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        if (rstn && rsp_valid && rsp_ready) rsp_q.push_back('{rsp_data, rsp_last, rsp_err, cyc});
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [PU_MEM_ADDR_NBITS-1:0] exp_addr(input int rci, input int off, input int i);
        int a;
        a = (int'(PU_CONNECTION_CONTEXT_MEM) << (RCI_NBITS + CCD)) + (rci << CCD) + ((off + i) % (1 << CCD));
        return a[PU_MEM_ADDR_NBITS-1:0];
    endfunction

    task automatic clear_logs();
        req_addr_q.delete();
        req_cyc_q.delete();
        ack_data_q.delete();
        ack_cyc_q.delete();
        rsp_q.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_req(input int rci, input int off, input int len, output int accept_cyc);
        int budget;
        budget     = 0;
        accept_cyc = -1;
        while (!req_ready && budget < 200) begin
            @(posedge clk);
            #2;
            budget++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL req_ready_wait: req_ready=%0b required 1", req_ready);
        end else begin
            req_valid  = 1'b1;
            req_rci    = rci[RCI_NBITS-1:0];
            req_offset = off[CCD-1:0];
            req_len    = len[2:0];
            @(posedge clk);
            #2;
            accept_cyc = cyc;
            req_valid  = 1'b0;
        end
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int k;
        k = 0;
        while (rsp_q.size() < n && k < budget) begin
            @(posedge clk);
            #2;
            k++;
        end
        n_checks++;
        if (rsp_q.size() < n) begin
            n_fail++;
            $display("[TB] FAIL rsp_wait: got %0d words required %0d", rsp_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_rci   = '0;
        req_offset = '0;
        req_len   = '0;
        ready_mode = 0;
        wait_cycles(3);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_req_ready: got %0b required 1", req_ready); end
        n_checks++; if (io_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_io_req: got %0b required 0", io_req); end
        n_checks++; if (io_cmd !== '0) begin n_fail++; $display("[TB] FAIL reset_io_cmd: got %0h required 0", io_cmd); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %0b required 0", rsp_valid); end
        n_checks++; if ({rsp_data, rsp_last, rsp_err} !== '0) begin n_fail++; $display("[TB] FAIL reset_rsp_fields: got %0h required 0", {rsp_data, rsp_last, rsp_err}); end
        n_checks++; if (stray_ack_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_stray: got %0d required 0", stray_ack_cnt); end
        rstn = 1'b1;
        wait_cycles(2);
    endtask

    task automatic test_single();
        int acc;
        clear_logs();
        ready_mode    = 1;
        ack_delay     = 4;
        fixed_data_en = 1;
        fixed_data    = 32'h0000_00A5;
        send_req(5, 3, 0, acc);
        wait_rsp(1, 50);
        wait_cycles(10);
        fixed_data_en = 0;
        n_checks++; if (req_addr_q.size() != 1) begin n_fail++; $display("[TB] FAIL single_req_count: got %0d required 1", req_addr_q.size()); end
        n_checks++; if (req_addr_q[0] !== exp_addr(5, 3, 0)) begin n_fail++; $display("[TB] FAIL single_addr: got %0h required %0h", req_addr_q[0], exp_addr(5, 3, 0)); end
        n_checks++; if (req_cyc_q[0] != acc) begin n_fail++; $display("[TB] FAIL single_req_latency: io_req cycle %0d required %0d", req_cyc_q[0], acc); end
        n_checks++; if (rsp_q.size() != 1) begin n_fail++; $display("[TB] FAIL single_rsp_count: got %0d required 1", rsp_q.size()); end
        n_checks++; if (rsp_q[0].data !== 32'hA5 || rsp_q[0].last !== 1'b1 || rsp_q[0].err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL single_rsp: data=%0h last=%0b err=%0b required a5/1/0", rsp_q[0].data, rsp_q[0].last, rsp_q[0].err);
        end
        n_checks++; if (rsp_q[0].c != req_cyc_q[0] + 5) begin n_fail++; $display("[TB] FAIL single_rsp_latency: rsp cycle %0d required %0d", rsp_q[0].c, req_cyc_q[0] + 5); end
    endtask

    task automatic test_wrap_burst();
        int acc, rci, off;
        clear_logs();
        rci        = $urandom_range(0, 255);
        off        = (1 << CCD) - 2;
        ready_mode = 1;
        ack_delay  = $urandom_range(1, 4);
        send_req(rci, off, 3, acc);
        wait_rsp(4, 100);
        wait_cycles(4);
        n_checks++; if (req_addr_q.size() != 4) begin n_fail++; $display("[TB] FAIL wrap_req_count: got %0d required 4", req_addr_q.size()); end
        for (int i = 0; i < 4 && i < req_addr_q.size() && i < rsp_q.size(); i++) begin
            n_checks++; if (req_addr_q[i] !== exp_addr(rci, off, i)) begin n_fail++; $display("[TB] FAIL wrap_addr[%0d]: got %0h required %0h", i, req_addr_q[i], exp_addr(rci, off, i)); end
            n_checks++; if (rsp_q[i].data !== ack_data_q[i] || rsp_q[i].last !== (i == 3) || rsp_q[i].err !== 1'b0) begin
                n_fail++; $display("[TB] FAIL wrap_rsp[%0d]: data=%0h last=%0b err=%0b required %0h/%0b/0", i, rsp_q[i].data, rsp_q[i].last, rsp_q[i].err, ack_data_q[i], (i == 3));
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc, rci, off;
        clear_logs();
        rci        = $urandom_range(0, 255);
        off        = $urandom_range(0, 15);
        ready_mode = 1;
        ack_delay  = 1;
        send_req(rci, off, 7, acc);
        wait_rsp(8, 100);
        wait_cycles(3);
        n_checks++; if (req_addr_q.size() != 8) begin n_fail++; $display("[TB] FAIL b2b_req_count: got %0d required 8", req_addr_q.size()); end
        for (int i = 1; i < req_cyc_q.size(); i++) begin
            n_checks++; if (req_cyc_q[i] - req_cyc_q[i-1] != 2) begin n_fail++; $display("[TB] FAIL b2b_gap[%0d]: got %0d cycles required 2", i, req_cyc_q[i] - req_cyc_q[i-1]); end
        end
        for (int i = 0; i < rsp_q.size() && i < ack_data_q.size(); i++) begin
            n_checks++; if (rsp_q[i].data !== ack_data_q[i] || rsp_q[i].last !== (i == 7)) begin n_fail++; $display("[TB] FAIL b2b_rsp[%0d]: data=%0h last=%0b required %0h/%0b", i, rsp_q[i].data, rsp_q[i].last, ack_data_q[i], (i == 7)); end
        end
    endtask

    task automatic test_backpressure();
        int acc, rci, off;
        clear_logs();
        rci        = $urandom_range(0, 255);
        off        = $urandom_range(0, 15);
        ready_mode = 0;
        ack_delay  = 2;
        send_req(rci, off, 7, acc);
        wait_cycles(60);
        n_checks++; if (req_addr_q.size() != 2) begin n_fail++; $display("[TB] FAIL bp_req_count: got %0d required 2", req_addr_q.size()); end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== ack_data_q[0]) begin n_fail++; $display("[TB] FAIL bp_head: valid=%0b data=%0h required 1/%0h", rsp_valid, rsp_data, ack_data_q[0]); end
        ready_mode = 2;
        wait_rsp(8, 400);
        wait_cycles(4);
        n_checks++; if (req_addr_q.size() != 8 || rsp_q.size() != 8) begin n_fail++; $display("[TB] FAIL bp_counts: reqs=%0d words=%0d required 8/8", req_addr_q.size(), rsp_q.size()); end
        for (int i = 0; i < rsp_q.size() && i < req_addr_q.size(); i++) begin
            n_checks++; if (req_addr_q[i] !== exp_addr(rci, off, i)) begin n_fail++; $display("[TB] FAIL bp_addr[%0d]: got %0h required %0h", i, req_addr_q[i], exp_addr(rci, off, i)); end
            n_checks++; if (rsp_q[i].data !== ack_data_q[i] || rsp_q[i].last !== (i == 7) || rsp_q[i].err !== 1'b0) begin
                n_fail++; $display("[TB] FAIL bp_rsp[%0d]: data=%0h last=%0b err=%0b required %0h/%0b/0", i, rsp_q[i].data, rsp_q[i].last, rsp_q[i].err, ack_data_q[i], (i == 7));
            end
        end
    endtask

    task automatic test_random_bursts();
        int acc, rci, off, len;
        for (int b = 0; b < 6; b++) begin
            clear_logs();
            rci        = $urandom_range(0, 255);
            off        = $urandom_range(0, 15);
            len        = $urandom_range(0, 7);
            ack_delay  = $urandom_range(1, 6);
            ready_mode = $urandom_range(1, 2);
            send_req(rci, off, len, acc);
            wait_rsp(len + 1, 400);
            wait_cycles(8);
            n_checks++; if (req_addr_q.size() != len + 1 || rsp_q.size() != len + 1) begin
                n_fail++; $display("[TB] FAIL rand_counts[%0d]: reqs=%0d words=%0d required %0d", b, req_addr_q.size(), rsp_q.size(), len + 1);
            end
            for (int i = 0; i < rsp_q.size() && i < req_addr_q.size(); i++) begin
                n_checks++; if (req_addr_q[i] !== exp_addr(rci, off, i)) begin n_fail++; $display("[TB] FAIL rand_addr[%0d.%0d]: got %0h required %0h", b, i, req_addr_q[i], exp_addr(rci, off, i)); end
                n_checks++; if (rsp_q[i].data !== ack_data_q[i] || rsp_q[i].last !== (i == len) || rsp_q[i].err !== 1'b0) begin
                    n_fail++; $display("[TB] FAIL rand_rsp[%0d.%0d]: data=%0h last=%0b err=%0b required %0h/%0b/0", b, i, rsp_q[i].data, rsp_q[i].last, rsp_q[i].err, ack_data_q[i], (i == len));
                end
            end
        end
    endtask

    task automatic test_timeout();
        int acc, rci, target;
        clear_logs();
        rci        = $urandom_range(0, 255);
        ready_mode = 1;
        ack_delay  = 3;
        mute_idx   = 1;
        send_req(rci, 6, 3, acc);
        wait_rsp(2, 1200);
        wait_cycles(10);
        mute_idx = -1;
        n_checks++; if (req_addr_q.size() != 2 || rsp_q.size() != 2) begin n_fail++; $display("[TB] FAIL tmo_counts: reqs=%0d words=%0d required 2/2", req_addr_q.size(), rsp_q.size()); end
        if (rsp_q.size() >= 2) begin
            n_checks++; if (rsp_q[0].data !== ack_data_q[0] || rsp_q[0].last !== 1'b0 || rsp_q[0].err !== 1'b0) begin
                n_fail++; $display("[TB] FAIL tmo_word0: data=%0h last=%0b err=%0b required %0h/0/0", rsp_q[0].data, rsp_q[0].last, rsp_q[0].err, ack_data_q[0]);
            end
            n_checks++; if (rsp_q[1].data !== '0 || rsp_q[1].last !== 1'b1 || rsp_q[1].err !== 1'b1) begin
                n_fail++; $display("[TB] FAIL tmo_err_entry: data=%0h last=%0b err=%0b required 0/1/1", rsp_q[1].data, rsp_q[1].last, rsp_q[1].err);
            end
            n_checks++; if (rsp_q[1].c != req_cyc_q[1] + 1023) begin n_fail++; $display("[TB] FAIL tmo_latency: err word cycle %0d required %0d", rsp_q[1].c, req_cyc_q[1] + 1023); end
        end
        n_checks++; if (stray_ack_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL tmo_stray_before: got %0d required 0", stray_ack_cnt); end
        target = req_cyc_q[0] + 1100;
        while (cyc < target) wait_cycles(1);
        late_ack_req = 1;
        wait_cycles(5);
        n_checks++; if (stray_ack_cnt !== 8'd1) begin n_fail++; $display("[TB] FAIL tmo_stray_after: got %0d required 1", stray_ack_cnt); end
        n_checks++; if (rsp_q.size() != 2 || rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL tmo_late_rsp: words=%0d valid=%0b required 2/0", rsp_q.size(), rsp_valid); end
    endtask

    task automatic test_ack_at_expiry();
        int acc, stray0;
        stray0 = int'(stray_ack_cnt);
        clear_logs();
        ready_mode = 1;
        ack_delay  = 1022;
        send_req(9, 1, 0, acc);
        wait_rsp(1, 1200);
        wait_cycles(3);
        n_checks++; if (rsp_q[0].data !== ack_data_q[0] || rsp_q[0].last !== 1'b1 || rsp_q[0].err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL expiry_ack_word: data=%0h last=%0b err=%0b required %0h/1/0", rsp_q[0].data, rsp_q[0].last, rsp_q[0].err, ack_data_q[0]);
        end
        n_checks++; if (int'(stray_ack_cnt) != stray0) begin n_fail++; $display("[TB] FAIL expiry_ack_stray: got %0d required %0d", stray_ack_cnt, stray0); end
        clear_logs();
        ack_delay = 1023;
        send_req(9, 2, 0, acc);
        wait_rsp(1, 1200);
        wait_cycles(3);
        n_checks++; if (rsp_q[0].data !== '0 || rsp_q[0].last !== 1'b1 || rsp_q[0].err !== 1'b1) begin
            n_fail++; $display("[TB] FAIL after_expiry_word: data=%0h last=%0b err=%0b required 0/1/1", rsp_q[0].data, rsp_q[0].last, rsp_q[0].err);
        end
        n_checks++; if (int'(stray_ack_cnt) != stray0 + 1) begin n_fail++; $display("[TB] FAIL after_expiry_stray: got %0d required %0d", stray_ack_cnt, stray0 + 1); end
    endtask

    task automatic test_reset_mid();
        int acc, k, rci, off;
        clear_logs();
        ready_mode = 0;
        ack_delay  = 3;
        send_req(17, 4, 3, acc);
        k = 0;
        while (req_addr_q.size() < 2 && k < 50) begin wait_cycles(1); k++; end
        n_checks++; if (rsp_valid !== 1'b1 || req_addr_q.size() != 2) begin n_fail++; $display("[TB] FAIL mid_setup: valid=%0b reqs=%0d required 1/2", rsp_valid, req_addr_q.size()); end
        rstn = 1'b0;
        #1;
        n_checks++; if ({req_ready, io_req, rsp_valid, rsp_last, rsp_err} !== 5'b10000) begin
            n_fail++; $display("[TB] FAIL mid_reset_ctl: ready/req/valid/last/err=%05b required 10000", {req_ready, io_req, rsp_valid, rsp_last, rsp_err});
        end
        n_checks++; if (io_cmd !== '0 || rsp_data !== '0 || stray_ack_cnt !== 8'd0) begin
            n_fail++; $display("[TB] FAIL mid_reset_data: cmd=%0h data=%0h stray=%0d required 0/0/0", io_cmd, rsp_data, stray_ack_cnt);
        end
        @(posedge clk);
        #2;
        rstn = 1'b1;
        wait_cycles(5);
        n_checks++; if (stray_ack_cnt !== 8'd1) begin n_fail++; $display("[TB] FAIL mid_late_ack_stray: got %0d required 1", stray_ack_cnt); end
        n_checks++; if (rsp_valid !== 1'b0 || req_addr_q.size() != 2) begin n_fail++; $display("[TB] FAIL mid_after_reset: valid=%0b reqs=%0d required 0/2", rsp_valid, req_addr_q.size()); end
        clear_logs();
        rci        = $urandom_range(0, 255);
        off        = $urandom_range(0, 15);
        ready_mode = 1;
        ack_delay  = 2;
        send_req(rci, off, 2, acc);
        wait_rsp(3, 100);
        wait_cycles(3);
        for (int i = 0; i < rsp_q.size() && i < req_addr_q.size(); i++) begin
            n_checks++; if (req_addr_q[i] !== exp_addr(rci, off, i) || rsp_q[i].data !== ack_data_q[i] || rsp_q[i].last !== (i == 2)) begin
                n_fail++; $display("[TB] FAIL mid_resume[%0d]: addr=%0h data=%0h last=%0b required %0h/%0h/%0b", i, req_addr_q[i], rsp_q[i].data, rsp_q[i].last, exp_addr(rci, off, i), ack_data_q[i], (i == 2));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap_burst();
        test_back_to_back();
        test_backpressure();
        test_random_bursts();
        test_timeout();
        test_ack_at_expiry();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pu_conn_context_rd.md
# pu_conn_context_rd

Per-PU read initiator for the connection context memory port. It accepts burst lookup requests (RCI, starting word offset, length) from a PU core. For each word it issues one `io_req`/`io_cmd` read toward the connection context responder, collects each `io_ack_data`, and delivers the words in order through a 2-entry response buffer with backpressure. One instance sits on each PU side of the `io_req[i]`/`io_ack[i]` lane.

## Interface
- `WIDTH_NBITS`, `` `PU_WIDTH_NBITS ``, data word width of `io_ack_data`/`rsp_data`.
- `LEN_NBITS`, 3, burst length field width; a burst is `req_len`+1 words (max 8).
- `TIMEOUT_NBITS`, 10, ack timeout counter width.
- Ports:
  - `clk` in 1: the single clock.
  - `` `RESET_SIG `` (`rstn`) in 1: reset, asynchronous, active-low.
  - `req_valid` in 1: lookup request valid.
  - `req_ready` out 1: request accepted when `req_valid` & `req_ready`.
  - `req_rci` in `` `RCI_NBITS ``: connection index.
  - `req_offset` in `` `CONNECTION_CONTEXT_DEPTH_NBITS ``: first word.
  - `req_len` in `LEN_NBITS`: words-1.
  - `io_req` out 1: single-cycle read strobe.
  - `io_cmd` out `io_type`: command, valid in the `io_req` cycle.
  - `io_ack` in 1: single-cycle read completion.
  - `io_ack_data` in `WIDTH_NBITS`: read data, valid with `io_ack`.
  - `rsp_valid` out 1: response word valid.
  - `rsp_ready` in 1: consumer accepts the word.
  - `rsp_data` out `WIDTH_NBITS`: response word.
  - `rsp_last` out 1: final word of the burst.
  - `rsp_err` out 1: word is a timeout marker (data 0).
  - `stray_ack_cnt` out 8: count of acks received with nothing outstanding; saturating.

## Operation
- `io_cmd.addr` layout:
  - `[`PU_MEM_MULTI_DEPTH_RANGE`]` = `` `PU_CONNECTION_CONTEXT_MEM ``.
  - `[RCI_NBITS-1+CCD_NBITS:CCD_NBITS]` = latched RCI.
  - `[CCD_NBITS-1:0]` = current offset.
- All other `io_cmd` fields are 0. `io_cmd` is driven all-zero outside `io_req` cycles.
- Offset sequencing:
  - Offset increments by 1 per word and wraps modulo 2^CCD_NBITS within the same RCI.
  - The upper RCI bits never change during a burst.
- At most one read is outstanding. The responder holds a 1-deep per-PU queue, and a second `io_req` before `io_ack` is a protocol violation.
- FSM states:
  - IDLE: `req_ready`=1. On accept, latch rci/offset/len, clear word count, go to ISSUE.
  - ISSUE: wait until buffer count + outstanding < 2. Assert `io_req` for one cycle, then go to WAIT.
  - WAIT: timeout counter runs.
    - On `io_ack`, push `{io_ack_data, last, err=0}`. If it was the last word go to IDLE, else increment offset and go to ISSUE.
    - On counter reaching all-ones, push `{0, last=1, err=1}`, abort the remaining words, and go to IDLE.
- A push only occurs when space is guaranteed by the credit check; buffer overflow is impossible.
- An `io_ack` in IDLE/ISSUE, or in WAIT after a timeout, is discarded and increments `stray_ack_cnt` (saturates at 255).
- `rsp_*` pop on `rsp_valid` & `rsp_ready`. Simultaneous push and pop is supported at full buffer.

## Timing
- Reset values: `req_ready`=1, `io_req`=0, `io_cmd`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_last`=0, `rsp_err`=0, `stray_ack_cnt`=0. The FSM is in IDLE and the buffer is empty.
- The request accepted at edge N gives `io_req` high in cycle N+1 (registered output).
- `io_ack` in cycle M gives a push at edge M, with `rsp_valid` high in cycle M+1.
- The next `io_req` is at cycle M+1 at the earliest (back-to-back) when credit allows.
- Timeout: the counter is cleared at `io_req`. The error push happens at the 2^TIMEOUT_NBITS-1th WAIT cycle without an ack.
- An `io_ack` in the same cycle as timeout expiry counts as a valid ack; the timeout is not taken.
- Reset mid-burst: all state is cleared immediately and the buffer is flushed. A later late ack counts as stray.

## Structure
- `type_package`:
  - reuse `io_type`.
  - add an `rsp_entry_t` typedef {data, last, err}.
- Address constants (`` `PU_CONNECTION_CONTEXT_MEM ``, `` `PU_MEM_MULTI_DEPTH_RANGE ``, `` `RCI_NBITS ``, `` `CONNECTION_CONTEXT_DEPTH_NBITS ``) come from `defines.vh`; no local copies.
- One sub-module: `sfifo2f_fo` (width = `$bits(rsp_entry_t)`, depth 2) serves as the response buffer. It exposes count for the credit check.

## Test plan
- Single read, RCI=5, offset=3, len=0; responder acks 4 cycles after `io_req` with 0xA5:
  - exactly one `io_req` with RCI field 5 and offset 3;
  - `rsp_data`=0xA5, `rsp_last`=1, `rsp_err`=0.
- Burst, offset=2^CCD-2, len=3, `rsp_ready`=1:
  - four `io_req`s with offsets 2^CCD-2, 2^CCD-1, 0, 1, RCI unchanged;
  - `rsp_last` only on the 4th word.
- `rsp_ready`=0 for a len=7 burst: exactly 2 words are buffered and no third `io_req` issues. Releasing `rsp_ready` resumes the burst in order with no loss.
- Responder silent for 1023 cycles on word 2 of len=3: one `rsp_err`=1/`rsp_last`=1 entry after word 1. A late ack at cycle 1100 makes `stray_ack_cnt`=1 and creates no response.
- Ack and timeout expiry in the same cycle: the data word is delivered with `rsp_err`=0.
- `rstn` asserted while in WAIT with 1 buffered word: all outputs return to reset values and the next request proceeds normally.
